// File: rtl/data_memory_rv32_pkg.sv
//==============================================================================
// Module      : data_memory_rv32_pkg
// Description : Shared widths, FSM state encoding and the byte-address decode
//               helper for the rv32 data memory responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package data_memory_rv32_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned BYTE_LANES = 4;

    // Responder FSM: WAIT burns the latency, RESPOND is the last in-flight cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Result of decoding a byte address against the memory window
    typedef struct packed {
        logic [WORD_WIDTH-3:0] index;
        logic                  in_range;
        logic                  aligned;
    } decode_t;

    // Word index relative to the base, plus window and alignment flags
    function automatic decode_t decode_address(
        input logic [WORD_WIDTH-1:0] address,
        input logic [WORD_WIDTH-1:0] base,
        input logic [WORD_WIDTH-1:0] depth_words
    );
        decode_t result;
        result.index    = (WORD_WIDTH-2)'((address - base) >> 2);
        result.in_range = (address >= base) && ({2'b00, result.index} < depth_words);
        result.aligned  = (address[1:0] == 2'b00);
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_rv32_array.sv
//==============================================================================
// Module      : data_memory_rv32_array
// Description : Word storage with a byte-masked synchronous write port and an
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_memory_rv32_array
    import data_memory_rv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned INDEX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                   clock,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [WORD_WIDTH-1:0]  write_value,
    input  logic [BYTE_LANES-1:0]  write_byte_enable,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [WORD_WIDTH-1:0]  read_value
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // One write port per byte lane so a masked store leaves other lanes intact
    for (genvar lane = 0; lane < BYTE_LANES; lane++) begin : g_lane
        always_ff @(posedge clock) begin
            if (write_enable && write_byte_enable[lane]) begin
                mem_q[write_index][lane*8 +: 8] <= write_value[lane*8 +: 8];
            end
        end
    end

    // Read port sees the array before this edge's write lands
    assign read_value = mem_q[read_index];

endmodule

`default_nettype wire

// File: rtl/data_memory_rv32.sv
//==============================================================================
// Module      : data_memory_rv32
// Description : Data memory responder for the rv32 core. Loads complete after
//               READ_LATENCY edges, stores commit in one edge with a byte mask,
//               and illegal accesses raise a one-cycle memory_error pulse.
//               Optional macro DATA_MEMORY_RV32_TRACE_EN compiles in
//               simulation-only store/response trace lines.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_memory_rv32
    import data_memory_rv32_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH_WORDS = 256,
    parameter int unsigned READ_LATENCY       = 2,
    parameter logic [31:0] BASE_ADDRESS       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        memory_read_request,
    input  logic [31:0] memory_read_address,
    output logic [31:0] memory_read_value,
    output logic        memory_read_valid,
    output logic        memory_busy,
    input  logic        memory_write_request,
    input  logic [31:0] memory_write_address,
    input  logic [31:0] memory_write_value,
    input  logic [3:0]  memory_write_byte_enable,
    output logic        memory_error
);

    localparam int unsigned INDEX_WIDTH =
        (MEMORY_DEPTH_WORDS > 1) ? $clog2(MEMORY_DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_WORDS_32  = 32'(MEMORY_DEPTH_WORDS);
    // WAIT runs READ_LATENCY-1 cycles, then RESPOND is the final in-flight cycle
    localparam logic [3:0]  LATENCY_PRELOAD =
        (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam bit          SINGLE_CYCLE    = (READ_LATENCY == 1);

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [31:0]     read_address_q, read_address_d;
    logic            read_valid_q, read_valid_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic [31:0]     read_value_q, read_value_d;

    decode_t         write_decode;
    decode_t         response_decode;
    logic            read_accept;
    logic            write_attempt;
    logic            write_legal;
    logic            write_illegal;
    logic            response_illegal;
    logic [31:0]     array_read_value;
    logic            unused_index_bits;

    assign write_decode    = decode_address(memory_write_address, BASE_ADDRESS, DEPTH_WORDS_32);
    assign response_decode = decode_address(read_address_q, BASE_ADDRESS, DEPTH_WORDS_32);

    // Requests are taken in IDLE and RESPOND; WAIT blocks both loads and stores
    assign read_accept      = enable && memory_read_request && (state_q != WAIT);
    assign write_attempt    = enable && memory_write_request;
    assign write_legal      = write_attempt && (state_q != WAIT)
                              && write_decode.in_range && write_decode.aligned;
    assign write_illegal    = write_attempt && !write_legal;
    assign response_illegal = !(response_decode.in_range && response_decode.aligned);

    // Out-of-window indices alias into the array but are never committed or returned
    assign unused_index_bits = ^{write_decode.index[WORD_WIDTH-3:INDEX_WIDTH],
                                 response_decode.index[WORD_WIDTH-3:INDEX_WIDTH]};

    data_memory_rv32_array #(
        .DEPTH_WORDS (MEMORY_DEPTH_WORDS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_array (
        .clock             (clock),
        .write_enable      (write_legal),
        .write_index       (write_decode.index[INDEX_WIDTH-1:0]),
        .write_value       (memory_write_value),
        .write_byte_enable (memory_write_byte_enable),
        .read_index        (response_decode.index[INDEX_WIDTH-1:0]),
        .read_value        (array_read_value)
    );

    // Next-state, latency counter and registered-output computation
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        read_address_d = read_address_q;
        read_valid_d   = 1'b0;
        read_value_d   = '0;
        error_d        = write_illegal;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESPOND: begin
                // Data sampled here excludes a store landing on this same edge
                read_valid_d = 1'b1;
                read_value_d = response_illegal ? '0 : array_read_value;
                error_d      = write_illegal || response_illegal;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new load overrides the return to IDLE, giving back-to-back reads
        if (read_accept) begin
            read_address_d = memory_read_address;
            if (SINGLE_CYCLE) begin
                state_d = RESPOND;
                count_d = 4'd0;
            end else begin
                state_d = WAIT;
                count_d = LATENCY_PRELOAD;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any in-flight load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= 4'd0;
            read_address_q <= '0;
            read_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            read_value_q   <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            read_address_q <= read_address_d;
            read_valid_q   <= read_valid_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            read_value_q   <= read_value_d;
        end
    end

    assign memory_read_value = read_value_q;
    assign memory_read_valid = read_valid_q;
    assign memory_busy       = busy_q;
    assign memory_error      = error_q;

`ifdef DATA_MEMORY_RV32_TRACE_EN
    // Simulation trace of committed stores and of each read response
    always_ff @(posedge clock) begin
        if (!reset && write_legal) begin
            $display("%0t data_memory_rv32 store addr=%h value=%h mask=%b",
                     $time, memory_write_address, memory_write_value,
                     memory_write_byte_enable);
        end
        if (!reset && (state_q == RESPOND)) begin
            $display("%0t data_memory_rv32 read addr=%h value=%h error=%b",
                     $time, read_address_q, read_value_d, response_illegal);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_rv32.sv
//==============================================================================
// Module      : tb_data_memory_rv32
// Description : Scoreboard bench for data_memory_rv32 with a word-array
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_memory_rv32;

    localparam int unsigned DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        memory_read_request = 1'b0;
    logic [31:0] memory_read_address = '0;
    logic [31:0] memory_read_value;
    logic        memory_read_valid;
    logic        memory_busy;
    logic        memory_write_request = 1'b0;
    logic [31:0] memory_write_address = '0;
    logic [31:0] memory_write_value = '0;
    logic [3:0]  memory_write_byte_enable = '0;
    logic        memory_error;

    always #5 clock = ~clock;

    data_memory_rv32 #(
        .MEMORY_DEPTH_WORDS (DEPTH),
        .READ_LATENCY       (LAT),
        .BASE_ADDRESS       (BASE)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .memory_read_request      (memory_read_request),
        .memory_read_address      (memory_read_address),
        .memory_read_value        (memory_read_value),
        .memory_read_valid        (memory_read_valid),
        .memory_busy              (memory_busy),
        .memory_write_request     (memory_write_request),
        .memory_write_address     (memory_write_address),
        .memory_write_value       (memory_write_value),
        .memory_write_byte_enable (memory_write_byte_enable),
        .memory_error             (memory_error)
    );

    typedef struct {
        int          due;
        logic [31:0] value;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    bit          store_err_at[int];
    logic [31:0] mem_model [DEPTH];
    int          last_accept = -1000;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit legal_addr(input logic [31:0] a);
        longint unsigned off;
        if (a < BASE) return 1'b0;
        off = longint'(a) - longint'(BASE);
        return (a[1:0] == 2'b00) && ((off / 4) < DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Effect of the upcoming edge e: a load may start once the previous one
    // has had LAT edges; stores in that gap are dropped
    task automatic model_edge(input int e);
        bit    blocked;
        resp_t r;
        blocked = (e < last_accept + LAT);
        if (enable && memory_write_request) begin
            if (!blocked && legal_addr(memory_write_address)) begin
                for (int lane = 0; lane < 4; lane++)
                    if (memory_write_byte_enable[lane])
                        mem_model[word_of(memory_write_address)][lane*8 +: 8] =
                            memory_write_value[lane*8 +: 8];
            end else begin
                store_err_at[e] = 1'b1;
            end
        end
        if (enable && memory_read_request && !blocked) begin
            last_accept = e;
            r.due   = e + LAT;
            r.err   = !legal_addr(memory_read_address);
            r.value = r.err ? 32'h0 : mem_model[word_of(memory_read_address)];
            sb.push_back(r);
        end
    endtask

    task automatic drive(input logic en, input logic rr, input logic [31:0] ra,
                         input logic wr, input logic [31:0] wa, input logic [31:0] wv,
                         input logic [3:0] be);
        @(negedge clock);
        enable                   = en;
        memory_read_request      = rr;
        memory_read_address      = ra;
        memory_write_request     = wr;
        memory_write_address     = wa;
        memory_write_value       = wv;
        memory_write_byte_enable = be;
        if (!reset) model_edge(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clock);
        reset                = 1'b1;
        enable               = 1'b0;
        memory_read_request  = 1'b0;
        memory_write_request = 1'b0;
        sb.delete();
        store_err_at.delete();
        last_accept = -1000;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned s;
        logic [7:0]  w;
        s = $urandom_range(0, 19);
        w = 8'($urandom_range(0, 15));
        if (s < 15) return {22'd0, w, 2'b00};
        if (s < 17) return {22'd0, w, 2'($urandom_range(1, 3))};
        if (s < 19) return 32'h400 + {22'd0, w, 2'b00};
        return $urandom;
    endfunction

    // Monitor: compares outputs each cycle against the scoreboard
    initial begin
        resp_t exp_r;
        bit    exp_valid;
        bit    exp_err;
        bit    exp_busy;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                check("reset_outputs",
                      {28'd0, memory_read_valid, memory_busy, memory_error, memory_read_value},
                      64'd0);
                continue;
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                void'(sb.pop_front());
                errors++;
                checks++;
                $display("FAIL missed_response cycle=%0d actual=none required=valid", cyc);
            end
            exp_valid = (sb.size() > 0) && (sb[0].due == cyc);
            exp_err   = store_err_at.exists(cyc);
            if (store_err_at.exists(cyc)) store_err_at.delete(cyc);
            check("read_valid", 64'(memory_read_valid), 64'(exp_valid));
            if (exp_valid) begin
                exp_r = sb.pop_front();
                exp_err = exp_err || exp_r.err;
                if (memory_read_valid) check("read_value", 64'(memory_read_value), 64'(exp_r.value));
            end
            check("error", 64'(memory_error), 64'(exp_err));
            exp_busy = (cyc >= last_accept) && (cyc < last_accept + LAT);
            check("busy", 64'(memory_busy), 64'(exp_busy));
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++)
            drive(1'b1, 1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom, 4'hF);
        idle(2);

        // Store then load
        drive(1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0,  32'h0,         4'h0);
        idle(4);

        // Byte-masked store
        drive(1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'h1122_3344, 4'hF);
        drive(1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  32'h0,         4'h0);
        idle(4);

        // Illegal accesses: misaligned read, out-of-range store and read
        drive(1'b1, 1'b1, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(4);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
        idle(1);
        drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(4);
        drive(1'b1, 1'b1, 32'(DEPTH * 4), 1'b0, 32'h0, 32'h0, 4'h0);
        idle(4);

        // Store during WAIT is dropped; held read request runs back-to-back
        drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0,  32'h0,         4'h0);
        drive(1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h1234_5678, 4'hF);
        idle(4);
        repeat (7) drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(4);

        // Load completes even when enable drops
        drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'h0, 4'hF);
        idle(2);

        // Reset one cycle after acceptance, then a fresh read
        drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        apply_reset(2);
        drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(4);

        // Write-first on simultaneous store and read
        drive(1'b1, 1'b1, 32'h30, 1'b1, 32'h30, 32'h5A5A_5A5A, 4'hF);
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset($urandom_range(1, 2));
            end else begin
                drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                      $urandom_range(0, 2) == 0, rand_addr(), $urandom, 4'($urandom));
            end
        end

        idle(LAT + 4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_rv32.md
# data_memory_rv32

Word-organised data memory responder for the rv32 core: it answers the core's load requests on `memory_read_address`/`memory_read_value` after a fixed, parameterised latency and commits byte-masked stores in one cycle. It sits between the execute stage's load/store path and the test bench, as the responder end of the core's memory-read interface. The block flags misaligned, out-of-range and rejected accesses with a one-cycle error pulse.

## Interface
- `MEMORY_DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two.
- `READ_LATENCY`, 2: clock edges from read acceptance to `memory_read_valid`; legal range 1..15.
- `BASE_ADDRESS`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `enable` input 1: gates acceptance of new requests only.
- `memory_read_request` input 1: load request, sampled at each rising edge.
- `memory_read_address` input 32: byte address of the load.
- `memory_read_value` output 32: load data, valid while `memory_read_valid` is high.
- `memory_read_valid` output 1: one-cycle response strobe.
- `memory_busy` output 1: a load is in flight; new requests are ignored while high.
- `memory_write_request` input 1: store request.
- `memory_write_address` input 32: byte address of the store.
- `memory_write_value` input 32: store data; lane i is bits [8i+7:8i].
- `memory_write_byte_enable` input 4: per-lane write mask.
- `memory_error` output 1: one-cycle pulse on an illegal access.

## Operation
- **Address decode.** Index = (address − BASE_ADDRESS) >> 2.
  - In range when address ≥ BASE_ADDRESS and index < MEMORY_DEPTH_WORDS.
  - Misaligned when address[1:0] ≠ 0.
- **FSM states.** IDLE, WAIT, RESPOND; a 4-bit latency counter.
- **Read acceptance.** A read is accepted at an edge where the state is IDLE or RESPOND, `enable`=1 and `memory_read_request`=1. At acceptance the address is latched.
  - READ_LATENCY=1: next state is RESPOND.
  - Otherwise: next state is WAIT, counter = READ_LATENCY−2.
- **WAIT.** Counter decrements each edge; at 0 the next state is RESPOND.
- **RESPOND.** `memory_read_valid`=1. The state returns to IDLE unless a new read is accepted at that same edge, which gives back-to-back operation.
- **In-flight loads.** A load continues to completion when `enable` drops.
- **Illegal read.** A misaligned or out-of-range read still completes with normal timing. `memory_read_value`=0 and `memory_error`=1 in the RESPOND cycle.
- **Store acceptance.** A store is accepted at an edge where `enable`=1, `memory_write_request`=1 and the state is not WAIT.
  - Lanes with byte enable 1 are updated at that edge.
  - byte_enable=4'b0000 is a legal no-op.
- **Illegal store.** A store that is misaligned, out of range, or requested during WAIT is dropped. `memory_error`=1 for the following cycle.
- **Simultaneous read and store at one edge.** Write-first: the store commits at that edge and the read returns the new data.
- **Reset.**
  - Asserted at any time: state=IDLE, counter=0, `memory_read_valid`=0, `memory_busy`=0, `memory_error`=0, `memory_read_value`=0.
  - An in-flight read is aborted and never produces a valid.
  - Array contents are not cleared.

## Timing
- Read accepted at edge N: `memory_read_valid` is high from edge N+READ_LATENCY for exactly one cycle.
- `memory_busy` is high from edge N to edge N+READ_LATENCY; it is low in the RESPOND cycle.
- Store accepted at edge N: the data is readable by a read accepted at edge N.
- The error pulse for a store lasts from edge N to edge N+1. The error pulse for a read coincides with the valid cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Sustained throughput: one read every READ_LATENCY cycles.

## Configuration
- `DATA_MEMORY_RV32_TRACE_EN` defined: simulation-only `$display` lines are compiled in.
  - For every accepted store: time, address, value, byte mask.
  - For every read response: time, address, value, error flag.
- Undefined: no trace code is compiled. Cycle behaviour is identical in both cases.

## Structure
- Package `data_memory_rv32_pkg` holds:
  - WORD_WIDTH=32 and BYTE_LANES=4;
  - the FSM state enum (IDLE, WAIT, RESPOND);
  - the address-decode function returning index, in-range and aligned flags.
- Sub-module `data_memory_rv32_array` holds the storage array with a byte-masked synchronous write port and a read port. The FSM, latency counter and error logic stay in the top module.

## Test plan
- **Store then load, latency 2.** Reset, store 32'hDEAD_BEEF at 0x10 with mask 4'hF, read 0x10 → valid exactly 2 edges after acceptance with value 32'hDEAD_BEEF, busy high for 2 cycles, error 0.
- **Byte-masked store.** Store 32'h1122_3344 at 0x20 with mask 4'hF, then 32'hAABB_CCDD with mask 4'b0101 → read 0x20 returns 32'h11BB_33DD.
- **Illegal accesses.**
  - Read 0x13 → value 0, error and valid together.
  - Store at byte address 4×MEMORY_DEPTH_WORDS → error pulse one cycle after acceptance, array unchanged.
- **Busy and back-to-back reads.** A store during WAIT is dropped with an error pulse. A read request held high in RESPOND is accepted back-to-back, giving valid every 2 cycles.
- **Reset mid-read.** Assert reset one cycle after read acceptance → valid never asserts, all outputs 0. A fresh read afterwards completes normally.
- **Write-first.** Simultaneous store 32'h5A5A_5A5A and read at 0x30 → read returns 32'h5A5A_5A5A.
